// File: rtl/dma_desc_scheduler.sv
// Descriptor FIFO plus sequencer that programs the DMA engine one chunk at a time
// (SRC, DST, SIZE, CTRL), waits for its completion flag, clears it and advances.
module dma_desc_scheduler #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-3:0] REG_BASE   = 14'h2000,
    parameter int                    DEPTH      = 4,
    parameter int                    MAX_CHUNK  = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [DATA_WIDTH-1:0]   desc_src,
    input  logic [DATA_WIDTH-1:0]   desc_dst,
    input  logic [15:0]             desc_size,
    input  logic                    desc_dir,
    output logic [ADDR_WIDTH-3:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_data,
    output logic                    reg_write,
    input  logic                    interrupt_intr,
    output logic                    interrupt_entr,
    output logic                    busy,
    output logic                    desc_done,
    output logic [7:0]              done_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RA_W  = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_SRC, ST_WR_DST, ST_WR_SIZE, ST_WR_CTRL, ST_WAIT, ST_CLR
    } state_t;

    // Largest engine transfer for the bytes left; SIZE[1:0] are dropped by the engine.
    function automatic logic [15:0] chunk_of(input logic [15:0] rem);
        logic [15:0] c;
        c = (rem > 16'(MAX_CHUNK)) ? 16'(MAX_CHUNK) : rem;
        return c & 16'hFFFC;
    endfunction

    logic [DATA_WIDTH-1:0] fifo_src  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_dst  [DEPTH];
    logic [15:0]           fifo_size [DEPTH];
    logic                  fifo_dir  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_next;

    state_t                state;
    logic [DATA_WIDTH-1:0] cur_src, cur_dst;
    logic [15:0]           remaining;
    logic                  dir;

    logic                  push, pop, last_chunk, idle_next;
    logic [15:0]           head_size, chunk;

    always_comb begin
        push       = desc_valid & desc_ready;
        pop        = (state == ST_IDLE) & (count != '0);
        head_size  = fifo_size[rd_ptr] & 16'hFFFC;
        chunk      = chunk_of(remaining);
        last_chunk = (remaining == chunk);
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        // A zero-length head is retired in IDLE, so the FSM stays there.
        idle_next  = ((state == ST_IDLE) & ((count == '0) | (head_size == 16'd0)))
                   | ((state == ST_CLR) & last_chunk);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src[wr_ptr]  <= desc_src;
            fifo_dst[wr_ptr]  <= desc_dst;
            fifo_size[wr_ptr] <= desc_size;
            fifo_dir[wr_ptr]  <= desc_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            desc_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            desc_ready <= (count_next != CNT_W'(DEPTH));
            busy       <= ~idle_next | (count_next != '0);
        end
    end

    // Outputs are set on the edge that enters each state, so they are valid during it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            reg_write      <= 1'b0;
            reg_addr       <= '0;
            reg_data       <= '0;
            interrupt_entr <= 1'b0;
            desc_done      <= 1'b0;
            done_count     <= 8'd0;
        end else begin
            desc_done      <= 1'b0;
            interrupt_entr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        cur_src   <= fifo_src[rd_ptr];
                        cur_dst   <= fifo_dst[rd_ptr];
                        remaining <= head_size;
                        dir       <= fifo_dir[rd_ptr];
                        if (head_size == 16'd0) begin
                            desc_done  <= 1'b1;
                            done_count <= done_count + 8'd1;
                        end else begin
                            state     <= ST_WR_SRC;
                            reg_write <= 1'b1;
                            reg_addr  <= REG_BASE;
                            reg_data  <= fifo_src[rd_ptr];
                        end
                    end
                end
                ST_WR_SRC: begin
                    state    <= ST_WR_DST;
                    reg_addr <= REG_BASE + RA_W'(1);
                    reg_data <= cur_dst;
                end
                ST_WR_DST: begin
                    state    <= ST_WR_SIZE;
                    reg_addr <= REG_BASE + RA_W'(2);
                    reg_data <= DATA_WIDTH'(chunk);
                end
                ST_WR_SIZE: begin
                    state    <= ST_WR_CTRL;
                    reg_addr <= REG_BASE + RA_W'(3);
                    reg_data <= {{(DATA_WIDTH-2){1'b0}}, dir, 1'b1};
                end
                ST_WR_CTRL: begin
                    state     <= ST_WAIT;
                    reg_write <= 1'b0;
                end
                ST_WAIT: begin
                    if (interrupt_intr) begin
                        state          <= ST_CLR;
                        interrupt_entr <= 1'b1;
                    end
                end
                ST_CLR: begin
                    cur_src   <= cur_src + DATA_WIDTH'(chunk);
                    cur_dst   <= cur_dst + DATA_WIDTH'(chunk);
                    remaining <= remaining - chunk;
                    if (last_chunk) begin
                        state      <= ST_IDLE;
                        desc_done  <= 1'b1;
                        done_count <= done_count + 8'd1;
                    end else begin
                        state     <= ST_WR_SRC;
                        reg_write <= 1'b1;
                        reg_addr  <= REG_BASE;
                        reg_data  <= cur_src + DATA_WIDTH'(chunk);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
